// File: rtl/cordic_post.sv
// CORDIC post-stage: gain-compensates magnitude (shift-add), unwraps phase (CORDIC_POST_UNWRAP_EN), 17-cycle latency.
// 2-entry valid/ready output queue; PUSH stalls when full and in_valid outside IDLE is dropped and counted.

module cordic_post_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         wr_fire;
    logic         rd_fire;

    assign rd_vld  = (count != 2'd0);
    assign rd_dat  = mem[rd_ptr];
    assign rd_fire = rd_vld && rd_rdy;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign wr_rdy  = (count != 2'd2) || rd_fire;
    assign wr_fire = wr_vld && wr_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_fire)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(wr_fire) - 2'(rd_fire);
        end
    end
endmodule

module cordic_post #(
    parameter int GAIN_K  = 19898,
    parameter int PHASE_W = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [15:0]        angle_in,
    input  logic signed [15:0]        mag_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               out_mag,
    output logic signed [15:0]        out_angle,
    output logic signed [PHASE_W-1:0] out_phase,
    output logic [7:0]                drop_cnt,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, MUL, PUSH} state_t;

    typedef struct packed {
        logic [15:0]               mag;
        logic signed [15:0]        angle;
        logic signed [PHASE_W-1:0] phase;
    } entry_t;

    localparam logic [31:0] GAIN = 32'(GAIN_K);

    state_t                    state;
    state_t                    state_nxt;
    logic [15:0]               mag_q;
    logic signed [15:0]        angle_q;
    logic [31:0]               acc;
    logic [3:0]                bit_cnt;
    logic                      accept;
    logic                      drop;
    logic                      push_vld;
    logic                      push_rdy;
    entry_t                    push_dat;
    entry_t                    head_dat;
    logic signed [PHASE_W-1:0] phase_out;

    assign accept = (state == IDLE) && in_valid;
    assign drop   = (state != IDLE) && in_valid;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push_vld  = 1'b0;
        case (state)
            IDLE: if (in_valid) state_nxt = MUL;
            MUL:  if (bit_cnt == 4'd15) state_nxt = PUSH;
            PUSH: begin
                push_vld = 1'b1;
                if (push_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q    <= '0;
            angle_q  <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                // Negative magnitudes are clamped so the product never exceeds 15 x 15 bits.
                mag_q   <= mag_in[15] ? 16'd0 : mag_in;
                angle_q <= angle_in;
                acc     <= '0;
                bit_cnt <= '0;
            end else if (state == MUL) begin
                if (mag_q[bit_cnt])
                    acc <= acc + (GAIN << bit_cnt);
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (drop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef CORDIC_POST_UNWRAP_EN
    logic signed [15:0]        prev_angle;
    logic signed [PHASE_W-1:0] phase_acc;
    logic                      first;
    logic signed [15:0]        delta;

    // Wraps mod 2^16, giving the shortest signed step between angles.
    assign delta = angle_in - prev_angle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_angle <= '0;
            phase_acc  <= '0;
            first      <= 1'b1;
        end else if (accept) begin
            if (first)
                phase_acc <= {{(PHASE_W-16){angle_in[15]}}, angle_in};
            else
                phase_acc <= phase_acc + {{(PHASE_W-16){delta[15]}}, delta};
            prev_angle <= angle_in;
            first      <= 1'b0;
        end
    end

    assign phase_out = phase_acc;
`else
    assign phase_out = {{(PHASE_W-16){angle_q[15]}}, angle_q};
`endif

    assign push_dat.mag   = acc[30:15];
    assign push_dat.angle = angle_q;
    assign push_dat.phase = phase_out;

    wire unused_acc_bits = ^{acc[31], acc[14:0]};

    cordic_post_fifo #(.W($bits(entry_t))) u_queue (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .wr_rdy (push_rdy),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head_dat)
    );

    assign out_mag   = head_dat.mag;
    assign out_angle = head_dat.angle;
    assign out_phase = head_dat.phase;
endmodule

// File: tb/tb_cordic_post.sv
// Directed bench for cordic_post: gain, unwrap, drops, backpressure, push/pop overlap, reset mid-MUL.
module tb_cordic_post;
`ifdef CORDIC_POST_UNWRAP_EN
    localparam bit UNWRAP = 1'b1;
`else
    localparam bit UNWRAP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] angle_in = '0;
    logic signed [15:0] mag_in = '0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [15:0]        out_mag;
    logic signed [15:0] out_angle;
    logic signed [23:0] out_phase;
    logic [7:0]         drop_cnt;
    logic               busy;

    int tests = 0;
    int fails = 0;
    int lat;

    always #5 clk = ~clk;

    cordic_post #(.GAIN_K(19898), .PHASE_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .angle_in  (angle_in),
        .mag_in    (mag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_angle (out_angle),
        .out_phase (out_phase),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_wait(input int ang, input int mag, output int cycles);
        in_valid = 1'b1;
        angle_in = 16'(ang);
        mag_in   = 16'(mag);
        tick();
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic pop;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_mag", 32'(out_mag), 0);
        check("rst_out_angle", 32'(out_angle), 0);
        check("rst_out_phase", 32'(out_phase), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Gain compensation and latency
        send_wait(100, 16384, lat);
        check("gain1_latency", lat, 17);
        check("gain1_mag", 32'(out_mag), 9949);
        check("gain1_angle", 32'(out_angle), 100);
        check("gain1_phase", 32'(out_phase), 100);
        check("gain1_busy_low", 32'(busy), 0);
        pop();
        send_wait(200, 32767, lat);
        check("gain2_latency", lat, 17);
        check("gain2_mag", 32'(out_mag), 19897);
        check("gain2_phase", 32'(out_phase), 200);
        pop();
        send_wait(300, -5, lat);
        check("gain3_latency", lat, 17);
        check("gain3_mag_clamp", 32'(out_mag), 0);
        check("gain3_phase", 32'(out_phase), 300);
        pop();

        // Unwrap across +pi
        do_reset();
        send_wait(30000, 0, lat);
        check("unwrap1_phase", 32'(out_phase), 30000);
        pop();
        send_wait(-30000, 0, lat);
        check("unwrap2_phase", 32'(out_phase), UNWRAP ? 35536 : -30000);
        check("unwrap2_angle", 32'(out_angle), -30000);
        pop();
        send_wait(0, 0, lat);
        check("unwrap3_phase", 32'(out_phase), UNWRAP ? 65536 : 0);
        pop();

        // Drop during MUL
        in_valid = 1'b1;
        angle_in = 16'sd1000;
        mag_in   = 16'sd0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        in_valid = 1'b1;
        angle_in = 16'sd5000;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("drop_out_valid", 32'(out_valid), 1);
        check("drop_angle", 32'(out_angle), 1000);
        check("drop_phase", 32'(out_phase), UNWRAP ? 66536 : 1000);
        check("drop_cnt_1", 32'(drop_cnt), 1);
        pop();
        check("drop_single_output", 32'(out_valid), 0);
        send_wait(2000, 0, lat);
        check("drop_next_phase", 32'(out_phase), UNWRAP ? 67536 : 2000);
        pop();

        // Backpressure: four samples 18 cycles apart with out_ready low
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            angle_in = 16'(11 * (k + 1));
            mag_in   = 16'sd16384;
            tick();
            in_valid = 1'b0;
            repeat (17) tick();
        end
        check("bp_busy_stall", 32'(busy), 1);
        check("bp_drop_cnt", 32'(drop_cnt), 1);
        check("bp_head_valid", 32'(out_valid), 1);
        check("bp_head_angle", 32'(out_angle), 11);
        in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        check("drop_cnt_sat", 32'(drop_cnt), 255);
        check("bp_busy_still", 32'(busy), 1);

        // Release: stalled PUSH writes in the same cycle as the pop
        pop();
        check("pp_busy_low", 32'(busy), 0);
        check("pp_valid", 32'(out_valid), 1);
        check("pp_head2_angle", 32'(out_angle), 22);
        check("pp_head2_mag", 32'(out_mag), 9949);
        pop();
        check("pp_head3_angle", 32'(out_angle), 33);
        check("pp_head3_phase", 32'(out_phase), 33);
        pop();
        check("pp_empty", 32'(out_valid), 0);

        // Reset in the middle of MUL with one entry queued
        send_wait(500, 0, lat);
        check("rm_queued", 32'(out_valid), 1);
        in_valid = 1'b1;
        angle_in = 16'sd7000;
        mag_in   = 16'sd100;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("rm_out_valid", 32'(out_valid), 0);
        check("rm_busy", 32'(busy), 0);
        check("rm_drop_cnt", 32'(drop_cnt), 0);
        check("rm_out_mag", 32'(out_mag), 0);
        check("rm_out_angle", 32'(out_angle), 0);
        check("rm_out_phase", 32'(out_phase), 0);
        rst_n = 1'b1;
        tick();
        repeat (30) tick();
        check("rm_no_stale", 32'(out_valid), 0);
        send_wait(-1234, 0, lat);
        check("rm_first_latency", lat, 17);
        check("rm_first_phase", 32'(out_phase), -1234);
        check("rm_first_angle", 32'(out_angle), -1234);
        pop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
